// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between the fetch stage (master) and imem (slave).
interface fetch_unit_if;
    logic        imem_read;
    logic [15:0] imem_address;
    logic        imem_resp;
    logic [15:0] imem_rdata;

    modport master (
        output imem_read,
        output imem_address,
        input  imem_resp,
        input  imem_rdata
    );

    modport slave (
        input  imem_read,
        input  imem_address,
        output imem_resp,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// LC-3b fetch stage: fetch PC, imem read handshake, IF/ID register, stall and flush handling.
// Define FETCH_SKID_BUF_EN to add a one-entry buffer that catches responses arriving during stall.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stall,
    input  logic                flush,
    input  logic [15:0]         redirect_pc,
    fetch_unit_if.master        imem,
    output logic [15:0]         inst,
    output logic [15:0]         pc,
    output logic                valid
);

    localparam logic [0:0] S_REQ     = 1'b0;
    localparam logic [0:0] S_DISCARD = 1'b1;

    logic [0:0]  state;
    logic [15:0] fetch_pc;
    logic [15:0] discard_pc;
    logic        read_req;

`ifdef FETCH_SKID_BUF_EN
    logic [15:0] buf_inst;
    logic [15:0] buf_pc;
    logic        buf_valid;
`endif

    always_comb begin
        read_req = 1'b1;
`ifdef FETCH_SKID_BUF_EN
        // Nowhere to put another word while the buffer is full and decode is stalled.
        if (state == S_REQ && buf_valid && stall)
            read_req = 1'b0;
`endif
    end

    assign imem.imem_read    = reset_n & read_req;
    assign imem.imem_address = (state == S_DISCARD) ? discard_pc : fetch_pc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_REQ;
            fetch_pc   <= RESET_PC;
            discard_pc <= RESET_PC;
            inst       <= NOP_INST;
            pc         <= RESET_PC;
            valid      <= 1'b0;
`ifdef FETCH_SKID_BUF_EN
            buf_inst   <= NOP_INST;
            buf_pc     <= RESET_PC;
            buf_valid  <= 1'b0;
`endif
        end else if (flush) begin
            inst     <= NOP_INST;
            valid    <= 1'b0;
            fetch_pc <= redirect_pc;
`ifdef FETCH_SKID_BUF_EN
            buf_valid <= 1'b0;
`endif
            // An issued request cannot be aborted: keep its address on the bus until it completes.
            if (state == S_REQ && read_req && !imem.imem_resp) begin
                state      <= S_DISCARD;
                discard_pc <= fetch_pc;
            end else if (state == S_DISCARD && imem.imem_resp) begin
                state <= S_REQ;
            end
        end else if (state == S_DISCARD) begin
            if (imem.imem_resp)
                state <= S_REQ;
            if (!stall) begin
                inst  <= NOP_INST;
                valid <= 1'b0;
            end
        end else if (stall) begin
`ifdef FETCH_SKID_BUF_EN
            if (imem.imem_resp && !buf_valid) begin
                buf_inst  <= imem.imem_rdata;
                buf_pc    <= fetch_pc;
                buf_valid <= 1'b1;
                fetch_pc  <= fetch_pc + 16'd2;
            end
`endif
        end
`ifdef FETCH_SKID_BUF_EN
        // Draining wins over a same-cycle response; that word is re-read since fetch_pc holds.
        else if (buf_valid) begin
            inst      <= buf_inst;
            pc        <= buf_pc;
            valid     <= 1'b1;
            buf_valid <= 1'b0;
        end
`endif
        else if (imem.imem_resp) begin
            inst     <= imem.imem_rdata;
            pc       <= fetch_pc;
            valid    <= 1'b1;
            fetch_pc <= fetch_pc + 16'd2;
        end else begin
            inst  <= NOP_INST;
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall, flush/discard, wrap and mid-request reset.
module tb_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        flush;
    logic [15:0] redirect_pc;
    logic [15:0] inst;
    logic [15:0] pc;
    logic        valid;

    int unsigned total;
    int unsigned bad;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC (16'h0000),
        .NOP_INST (16'h0000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall       (stall),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .imem        (bus),
        .inst        (inst),
        .pc          (pc),
        .valid       (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic drive(input logic s, input logic f, input logic [15:0] rpc,
                         input logic r, input logic [15:0] rd);
        stall            = s;
        flush            = f;
        redirect_pc      = rpc;
        bus.imem_resp    = r;
        bus.imem_rdata   = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_ifid(input string tag, input logic [15:0] ei, input logic [15:0] ep,
                              input logic ev);
        check({tag, ".inst"}, inst, ei);
        check({tag, ".pc"}, pc, ep);
        check({tag, ".valid"}, {15'd0, valid}, {15'd0, ev});
    endtask

    task automatic check_bus(input string tag, input logic er, input logic [15:0] ea);
        check({tag, ".read"}, {15'd0, bus.imem_read}, {15'd0, er});
        check({tag, ".addr"}, bus.imem_address, ea);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        #1;
        check_bus("rst", 1'b0, 16'h0000);
        check_ifid("rst", 16'h0000, 16'h0000, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        check_bus("first_req", 1'b1, 16'h0000);

        // Back-to-back responses
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234);
        tick();
        check_ifid("acc0", 16'h1234, 16'h0000, 1'b1);
        check_bus("acc0", 1'b1, 16'h0002);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h5678);
        tick();
        check_ifid("acc2", 16'h5678, 16'h0002, 1'b1);
        check_bus("acc2", 1'b1, 16'h0004);

        // Three-cycle stall, response in the middle
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        tick();
        check_ifid("stall1", 16'h5678, 16'h0002, 1'b1);
        drive(1'b1, 1'b0, 16'h0000, 1'b1, 16'h9ABC);
        tick();
        check_ifid("stall2", 16'h5678, 16'h0002, 1'b1);
`ifdef FETCH_SKID_BUF_EN
        check_bus("stall2", 1'b0, 16'h0006);
`else
        check_bus("stall2", 1'b1, 16'h0004);
`endif
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        tick();
        check_ifid("stall3", 16'h5678, 16'h0002, 1'b1);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        tick();
`ifdef FETCH_SKID_BUF_EN
        check_ifid("drain", 16'h9ABC, 16'h0004, 1'b1);
        check_bus("drain", 1'b1, 16'h0006);
`else
        check_ifid("bubble", 16'h0000, 16'h0002, 1'b0);
        check_bus("reread", 1'b1, 16'h0004);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h9ABC);
        tick();
        check_ifid("acc4", 16'h9ABC, 16'h0004, 1'b1);
        check_bus("acc4", 1'b1, 16'h0006);
`endif

        // Flush while request to 0x0008 is outstanding
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111);
        tick();
        check_ifid("acc6", 16'h1111, 16'h0006, 1'b1);
        check_bus("acc6", 1'b1, 16'h0008);
        drive(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0000);
        tick();
        check_ifid("flush", 16'h0000, 16'h0006, 1'b0);
        check_bus("discard_hold", 1'b1, 16'h0008);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        tick();
        check_bus("discard_wait", 1'b1, 16'h0008);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'hDEAD);
        tick();
        check_ifid("discard_drop", 16'h0000, 16'h0006, 1'b0);
        check_bus("redirect", 1'b1, 16'h0040);

        // Flush with response in the same cycle
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222);
        tick();
        check_ifid("acc40", 16'h2222, 16'h0040, 1'b1);
        drive(1'b0, 1'b1, 16'h0100, 1'b1, 16'h3333);
        tick();
        check_ifid("flush_resp", 16'h0000, 16'h0040, 1'b0);
        check_bus("flush_resp", 1'b1, 16'h0100);

        // Redirect to 0xFFFE (via discard of 0x0100) and wrap
        drive(1'b0, 1'b1, 16'hFFFE, 1'b0, 16'h0000);
        tick();
        check_bus("wrap_discard", 1'b1, 16'h0100);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'hBEEF);
        tick();
        check_bus("wrap_req", 1'b1, 16'hFFFE);
        check_ifid("wrap_drop", 16'h0000, 16'h0040, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4444);
        tick();
        check_ifid("wrap", 16'h4444, 16'hFFFE, 1'b1);
        check_bus("wrap", 1'b1, 16'h0000);

        // Reset pulsed mid-request
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h5555);
        tick();
        check_bus("pre_rst", 1'b1, 16'h0002);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        #1;
        reset_n = 1'b0;
        #1;
        check_bus("mid_rst", 1'b0, 16'h0000);
        check_ifid("mid_rst", 16'h0000, 16'h0000, 1'b0);
        tick();
        reset_n = 1'b1;
        #1;
        check_bus("restart", 1'b1, 16'h0000);
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777);
        tick();
        check_ifid("restart", 16'h7777, 16'h0000, 1'b1);
        check_bus("restart_next", 1'b1, 16'h0002);

        drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
